step_controller: RTL and testbench

STEP_CONTROLLER -- requirements
Module: step_controller

---
 rtl/step_controller.sv | 163 ++++++++++++++++
 tb/tb_step_controller.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_controller.sv
// -----------------------------------------------------------------------------
// step_controller
//
// Run/step/halt controller for a pipelined CPU. A host issues command bytes
// (run, single-step, pause, clear) and the controller produces the pipeline
// advance enable, a one-cycle pipeline clear pulse and an optional count of
// cycles in which the pipeline was allowed to advance.
//
// Optional feature macro: STEP_CYCLE_COUNTER_EN
//   defined   : o_cycle_count is a saturating counter of cycles with o_step=1
//   undefined : no counter register, o_cycle_count is tied to zero
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_reset        asynchronous active-high reset
//   i_cmd_valid    command byte present on i_cmd
//   i_cmd          command code: 0x52 run, 0x53 step, 0x50 pause, 0x43 clear
//   o_cmd_ready    command can be accepted this cycle (low only in STEP)
//   i_halt         pipeline retired a HALT instruction this cycle
//   o_step         pipeline advance enable (high in RUN and STEP)
//   o_pipe_reset   one-cycle pipeline clear pulse following an accepted clear
//   o_state        current state (IDLE=0, RUN=1, STEP=2, HALTED=3)
//   o_done         high while HALTED
//   o_cycle_count  number of cycles with o_step high (saturating)
// -----------------------------------------------------------------------------
module step_controller #(
    parameter int NB     = 32,
    parameter int NB_CMD = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    input  logic [NB_CMD-1:0] i_cmd,
    output logic              o_cmd_ready,
    input  logic              i_halt,
    output logic              o_step,
    output logic              o_pipe_reset,
    output logic [1:0]        o_state,
    output logic              o_done,
    output logic [NB-1:0]     o_cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [NB_CMD-1:0] CMD_RUN   = NB_CMD'(8'h52);
    localparam logic [NB_CMD-1:0] CMD_STEP  = NB_CMD'(8'h53);
    localparam logic [NB_CMD-1:0] CMD_PAUSE = NB_CMD'(8'h50);
    localparam logic [NB_CMD-1:0] CMD_CLEAR = NB_CMD'(8'h43);

    state_t state_q;
    state_t state_d;
    logic   pipe_reset_q;
    logic   pipe_reset_d;
    logic   cmd_acc_s;
    logic   clear_s;

    // Handshake: the only state that refuses commands is the one-cycle STEP.
    assign o_cmd_ready = (state_q != ST_STEP);
    assign cmd_acc_s   = i_cmd_valid && o_cmd_ready;

    // Status outputs are pure decodes of the state register, so an
    // asynchronous reset drops o_step in the same cycle.
    assign o_step       = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign o_done       = (state_q == ST_HALTED);
    assign o_state      = state_q;
    assign o_pipe_reset = pipe_reset_q;

    // Next-state decode and clear request.
    always_comb begin
        state_d = state_q;
        clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc_s) begin
                    case (i_cmd)
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_CLEAR: clear_s = 1'b1;
                        default:   state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Halt wins over a simultaneous pause; the pause is still
                // consumed because o_cmd_ready is high in RUN.
                if (i_halt) begin
                    state_d = ST_HALTED;
                end else if (cmd_acc_s && (i_cmd == CMD_PAUSE)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                if (i_halt) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (cmd_acc_s && (i_cmd == CMD_CLEAR)) begin
                    state_d = ST_IDLE;
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pipe_reset_d = clear_s;
    end

    // Controller state and registered clear pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            pipe_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pipe_reset_q <= pipe_reset_d;
        end
    end

`ifdef STEP_CYCLE_COUNTER_EN
    logic [NB-1:0] count_q;
    logic [NB-1:0] count_d;

    // Saturating advance counter; clear overrides increment.
    always_comb begin
        if (clear_s) begin
            count_d = '0;
        end else if (o_step && (count_q != {NB{1'b1}})) begin
            count_d = count_q + NB'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_cycle_count = count_q;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_step_controller.sv
// -----------------------------------------------------------------------------
// Testbench for step_controller. A second instance with a 3-bit counter runs
// on the same stimulus so counter saturation is reachable in a few cycles.
// Expected observations are pushed to a scoreboard queue as each stimulus
// cycle is driven and popped/compared once the DUT has clocked it.
// -----------------------------------------------------------------------------
module tb_step_controller;

`ifdef STEP_CYCLE_COUNTER_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic        i_clk;
    logic        i_reset;
    logic        i_cmd_valid;
    logic [7:0]  i_cmd;
    logic        i_halt;
    logic        o_cmd_ready;
    logic        o_step;
    logic        o_pipe_reset;
    logic [1:0]  o_state;
    logic        o_done;
    logic [31:0] o_cycle_count;

    logic        s_cmd_ready;
    logic        s_step;
    logic        s_pipe_reset;
    logic [1:0]  s_state;
    logic        s_done;
    logic [2:0]  s_cycle_count;

    step_controller #(.NB(32), .NB_CMD(8)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd         (i_cmd),
        .o_cmd_ready   (o_cmd_ready),
        .i_halt        (i_halt),
        .o_step        (o_step),
        .o_pipe_reset  (o_pipe_reset),
        .o_state       (o_state),
        .o_done        (o_done),
        .o_cycle_count (o_cycle_count)
    );

    step_controller #(.NB(3), .NB_CMD(8)) dut_sat (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cmd_valid   (i_cmd_valid),
        .i_cmd         (i_cmd),
        .o_cmd_ready   (s_cmd_ready),
        .i_halt        (i_halt),
        .o_step        (s_step),
        .o_pipe_reset  (s_pipe_reset),
        .o_state       (s_state),
        .o_done        (s_done),
        .o_cycle_count (s_cycle_count)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        stp;
        logic        rdy;
        logic        dn;
        logic        pr;
        logic [31:0] cnt;
        logic [2:0]  sat;
        logic [1:0]  s_st;
    } exp_t;

    typedef struct packed {
        logic       v;
        logic [7:0] c;
        logic       h;
        logic [1:0] st;
        logic       pr;
        int         cnt;
    } stim_t;

    logic [$bits(exp_t)-1:0] obs_s;
    assign obs_s = {o_state, o_step, o_cmd_ready, o_done, o_pipe_reset,
                    o_cycle_count, s_cycle_count, s_state};

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    // Expected observation built from the state definitions.
    function automatic exp_t ex(input logic [1:0] st, input logic pr, input int cnt);
        exp_t e;
        int   c;
        c      = CE ? cnt : 0;
        e.st   = st;
        e.stp  = (st == 2'd1) || (st == 2'd2);
        e.rdy  = (st != 2'd2);
        e.dn   = (st == 2'd3);
        e.pr   = pr;
        e.cnt  = c;
        e.sat  = (c > 7) ? 3'd7 : c[2:0];
        e.s_st = st;
        return e;
    endfunction

    function automatic stim_t row(input logic v, input logic [7:0] c, input logic h,
                                  input logic [1:0] st, input logic pr, input int cnt);
        stim_t s;
        s.v = v; s.c = c; s.h = h; s.st = st; s.pr = pr; s.cnt = cnt;
        return s;
    endfunction

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [7:0] c, input logic h);
        i_cmd_valid = v;
        i_cmd       = c;
        i_halt      = h;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        i_cmd       = 8'h00;
        i_halt      = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        i_reset     = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd       = 8'h52;
        repeat (2) @(posedge i_clk);
        #1;
        sb_q.push_back(ex(2'd0, 1'b0, 0));
        e = sb_q.pop_front();
        n_checks++;
        if (obs_s !== e) begin
            n_fail++;
            $display("FAIL reset_hold: actual=%h required=%h", obs_s, e);
        end
        i_cmd_valid = 1'b0;
        i_cmd       = 8'h00;
        #3;
        i_reset = 1'b0;
        #1;
        sb_q.push_back(ex(2'd0, 1'b0, 0));
        e = sb_q.pop_front();
        n_checks++;
        if (obs_s !== e) begin
            n_fail++;
            $display("FAIL reset_release: actual=%h required=%h", obs_s, e);
        end
    endtask

    task automatic test_single_step();
        stim_t t[$];
        exp_t  e;
        t.push_back(row(1'b1, 8'h53, 1'b0, 2'd2, 1'b0, 0));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1));
        foreach (t[i]) begin
            sb_q.push_back(ex(t[i].st, t[i].pr, t[i].cnt));
            cyc(t[i].v, t[i].c, t[i].h);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL single_step[%0d]: actual=%h required=%h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_idle_ignores();
        stim_t t[$];
        exp_t  e;
        t.push_back(row(1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1));
        t.push_back(row(1'b0, 8'h00, 1'b1, 2'd0, 1'b0, 1));
        t.push_back(row(1'b1, 8'h50, 1'b0, 2'd0, 1'b0, 1));
        foreach (t[i]) begin
            sb_q.push_back(ex(t[i].st, t[i].pr, t[i].cnt));
            cyc(t[i].v, t[i].c, t[i].h);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL idle_ignores[%0d]: actual=%h required=%h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_run_pause();
        stim_t t[$];
        exp_t  e;
        t.push_back(row(1'b1, 8'h43, 1'b0, 2'd0, 1'b1, 0));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 0));
        t.push_back(row(1'b1, 8'h52, 1'b0, 2'd1, 1'b0, 0));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 1));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 2));
        t.push_back(row(1'b1, 8'h53, 1'b0, 2'd1, 1'b0, 3));
        t.push_back(row(1'b1, 8'h43, 1'b0, 2'd1, 1'b0, 4));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 5));
        t.push_back(row(1'b1, 8'h50, 1'b0, 2'd0, 1'b0, 6));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 6));
        foreach (t[i]) begin
            sb_q.push_back(ex(t[i].st, t[i].pr, t[i].cnt));
            cyc(t[i].v, t[i].c, t[i].h);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL run_pause[%0d]: actual=%h required=%h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_halt_priority();
        stim_t t[$];
        exp_t  e;
        t.push_back(row(1'b1, 8'h52, 1'b0, 2'd1, 1'b0, 6));
        t.push_back(row(1'b1, 8'h50, 1'b1, 2'd3, 1'b0, 7));
        t.push_back(row(1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 7));
        foreach (t[i]) begin
            sb_q.push_back(ex(t[i].st, t[i].pr, t[i].cnt));
            cyc(t[i].v, t[i].c, t[i].h);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL halt_priority[%0d]: actual=%h required=%h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_halted_clear();
        stim_t t[$];
        exp_t  e;
        t.push_back(row(1'b1, 8'h52, 1'b0, 2'd3, 1'b0, 7));
        t.push_back(row(1'b1, 8'h53, 1'b0, 2'd3, 1'b0, 7));
        t.push_back(row(1'b1, 8'h50, 1'b0, 2'd3, 1'b0, 7));
        t.push_back(row(1'b1, 8'h43, 1'b0, 2'd0, 1'b1, 0));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 0));
        foreach (t[i]) begin
            sb_q.push_back(ex(t[i].st, t[i].pr, t[i].cnt));
            cyc(t[i].v, t[i].c, t[i].h);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL halted_clear[%0d]: actual=%h required=%h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_back_to_back_step();
        stim_t t[$];
        exp_t  e;
        t.push_back(row(1'b1, 8'h53, 1'b0, 2'd2, 1'b0, 0));
        t.push_back(row(1'b1, 8'h52, 1'b0, 2'd0, 1'b0, 1));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1));
        t.push_back(row(1'b1, 8'h53, 1'b0, 2'd2, 1'b0, 1));
        t.push_back(row(1'b0, 8'h00, 1'b1, 2'd3, 1'b0, 2));
        t.push_back(row(1'b1, 8'h43, 1'b0, 2'd0, 1'b1, 0));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 0));
        foreach (t[i]) begin
            sb_q.push_back(ex(t[i].st, t[i].pr, t[i].cnt));
            cyc(t[i].v, t[i].c, t[i].h);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL back_to_back_step[%0d]: actual=%h required=%h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_saturation();
        stim_t t[$];
        exp_t  e;
        t.push_back(row(1'b1, 8'h52, 1'b0, 2'd1, 1'b0, 0));
        for (int k = 1; k <= 9; k++) begin
            t.push_back(row(1'b0, 8'h00, 1'b0, 2'd1, 1'b0, k));
        end
        t.push_back(row(1'b1, 8'h50, 1'b0, 2'd0, 1'b0, 10));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 10));
        t.push_back(row(1'b1, 8'h43, 1'b0, 2'd0, 1'b1, 0));
        foreach (t[i]) begin
            sb_q.push_back(ex(t[i].st, t[i].pr, t[i].cnt));
            cyc(t[i].v, t[i].c, t[i].h);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL saturation[%0d]: actual=%h required=%h", i, obs_s, e);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        stim_t t[$];
        stim_t u[$];
        exp_t  e;
        t.push_back(row(1'b1, 8'h52, 1'b0, 2'd1, 1'b0, 0));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 1));
        t.push_back(row(1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 2));
        foreach (t[i]) begin
            sb_q.push_back(ex(t[i].st, t[i].pr, t[i].cnt));
            cyc(t[i].v, t[i].c, t[i].h);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL reset_mid_run_pre[%0d]: actual=%h required=%h", i, obs_s, e);
            end
        end
        // Reset between edges: outputs must drop before the next rising edge.
        #2;
        i_reset = 1'b1;
        sb_q.push_back(ex(2'd0, 1'b0, 0));
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if (obs_s !== e) begin
            n_fail++;
            $display("FAIL reset_mid_run_async: actual=%h required=%h", obs_s, e);
        end
        #2;
        i_reset = 1'b0;
        // First command after release is taken on the very next edge.
        u.push_back(row(1'b1, 8'h53, 1'b0, 2'd2, 1'b0, 0));
        u.push_back(row(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1));
        foreach (u[i]) begin
            sb_q.push_back(ex(u[i].st, u[i].pr, u[i].cnt));
            cyc(u[i].v, u[i].c, u[i].h);
            e = sb_q.pop_front();
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL reset_mid_run_post[%0d]: actual=%h required=%h", i, obs_s, e);
            end
        end
    endtask

    initial begin
        i_reset     = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd       = 8'h00;
        i_halt      = 1'b0;
        test_reset();
        test_single_step();
        test_idle_ignores();
        test_run_pause();
        test_halt_priority();
        test_halted_clear();
        test_back_to_back_step();
        test_saturation();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
